// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Function : Round-robin sharing of one combinational ALU between two
//            requesters through an issue register and a response register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_out,
    output logic         rsp0_zero,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_out,
    output logic         rsp1_zero,

    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_ina,
    output logic [W-1:0] alu_inb,
    input  logic [W-1:0] alu_out,
    input  logic         alu_zero
);

    logic         r_s1_valid;
    logic         r_s1_owner;
    logic [3:0]   r_s1_op;
    logic [W-1:0] r_s1_a;
    logic [W-1:0] r_s1_b;

    logic         r_s2_valid;
    logic         r_s2_owner;
    logic [W-1:0] r_s2_out;
    logic         r_s2_zero;

    logic         r_rr_ptr;

    logic         w_s2_take;
    logic         w_s2_load;
    logic         w_s1_free;
    logic         w_winner;
    logic         w_accept;

    assign w_s2_take = r_s2_valid & (r_s2_owner ? rsp1_ready : rsp0_ready);
    assign w_s2_load = r_s1_valid & (~r_s2_valid | w_s2_take);
    assign w_s1_free = ~r_s1_valid | w_s2_load;

    // A lone requester wins outright; on a tie the pointer decides.
    always_comb begin
        w_winner = 1'b0;
        if (req0_valid && req1_valid) begin
            w_winner = r_rr_ptr;
        end else if (req1_valid) begin
            w_winner = 1'b1;
        end
    end

    assign req0_ready = w_s1_free & req0_valid & ~w_winner;
    assign req1_ready = w_s1_free & req1_valid &  w_winner;
    assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_owner <= 1'b0;
            r_s1_op    <= 4'b0000;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_rr_ptr   <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_owner <= w_winner;
            r_s1_op    <= w_winner ? req1_op : req0_op;
            r_s1_a     <= w_winner ? req1_a  : req0_a;
            r_s1_b     <= w_winner ? req1_b  : req0_b;
            r_rr_ptr   <= ~w_winner;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_owner <= 1'b0;
            r_s2_out   <= '0;
            r_s2_zero  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_owner <= r_s1_owner;
            r_s2_out   <= alu_out;
            r_s2_zero  <= alu_zero;
        end else if (w_s2_take) begin
            r_s2_valid <= 1'b0;
        end
    end

    // The ALU sees the issue register even when it is empty.
    assign alu_op     = r_s1_op;
    assign alu_ina    = r_s1_a;
    assign alu_inb    = r_s1_b;

    assign rsp0_valid = r_s2_valid & ~r_s2_owner;
    assign rsp1_valid = r_s2_valid &  r_s2_owner;
    assign rsp0_out   = r_s2_out;
    assign rsp1_out   = r_s2_out;
    assign rsp0_zero  = r_s2_zero;
    assign rsp1_zero  = r_s2_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Function : Self-checking bench for alu_arbiter with a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [W-1:0] rsp0_out, rsp1_out;
    logic         rsp0_zero, rsp1_zero;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_ina, alu_inb, alu_out;
    logic         alu_zero;

    alu_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_out(rsp0_out), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_out(rsp1_out), .rsp1_zero(rsp1_zero),
        .alu_op(alu_op), .alu_ina(alu_ina), .alu_inb(alu_inb),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_alu(input logic [3:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (op)
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0011: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b0100: r = a << b[4:0];
            4'b1001: r = $unsigned($signed(a) >>> b[4:0]);
            4'b0111: r = (a < b) ? 1 : 0;
            4'b1000: r = ($signed(a) < $signed(b)) ? 1 : 0;
            default: r = '0;
        endcase
        return {(r == '0), r};
    endfunction

    // The shared ALU lives in the bench.
    always_comb {alu_zero, alu_out} = ref_alu(alu_op, alu_ina, alu_inb);

    typedef struct {
        bit           owner;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] out;
        bit           zero;
        bit           vis;
    } ent_t;

    typedef struct {
        bit           port;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] out;
        bit           zero;
    } vec_t;

    // In-flight operations in grant order; at most two may be held.
    ent_t q[$];
    bit   rr;
    bit   last_acc0, last_acc1;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit   hv, take, free, win, e0, e1, has_s1;
        int   sz;
        ent_t e, n;
        logic [W:0] res;
        @(negedge clk);
        sz   = q.size();
        hv   = (sz > 0) && q[0].vis;
        take = hv && (q[0].owner ? rsp1_ready : rsp0_ready);
        free = (sz - (take ? 1 : 0)) <= 1;
        win  = (req0_valid && req1_valid) ? rr : req1_valid;
        e0   = free && req0_valid && !win;
        e1   = free && req1_valid && win;
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("rsp0_valid", rsp0_valid, hv && !q[0].owner);
        chk("rsp1_valid", rsp1_valid, hv && q[0].owner);
        if (hv) begin
            chk(q[0].owner ? "rsp1_out" : "rsp0_out", q[0].owner ? rsp1_out : rsp0_out, q[0].out);
            chk(q[0].owner ? "rsp1_zero" : "rsp0_zero", q[0].owner ? rsp1_zero : rsp0_zero, q[0].zero);
        end
        has_s1 = 1'b0;
        if (sz == 2) begin
            e = q[1]; has_s1 = 1'b1;
        end else if (sz == 1 && !q[0].vis) begin
            e = q[0]; has_s1 = 1'b1;
        end
        if (has_s1) begin
            chk("alu_op", alu_op, e.op);
            chk("alu_ina", alu_ina, e.a);
            chk("alu_inb", alu_inb, e.b);
        end
        n.owner = win;
        n.op  = win ? req1_op : req0_op;
        n.a   = win ? req1_a  : req0_a;
        n.b   = win ? req1_b  : req0_b;
        res   = ref_alu(n.op, n.a, n.b);
        n.out = res[W-1:0];
        n.zero = res[W];
        n.vis = 1'b0;
        @(posedge clk);
        if (take) void'(q.pop_front());
        foreach (q[i]) q[i].vis = 1'b1;
        if (e0 || e1) begin
            q.push_back(n);
            rr = ~win;
        end
        last_acc0 = e0;
        last_acc1 = e1;
        #1;
    endtask

    task automatic set_req(input bit port, input logic [3:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (port) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
    endtask

    task automatic apply_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst rsp0_valid", rsp0_valid, 1'b0);
        chk("rst rsp1_valid", rsp1_valid, 1'b0);
        q.delete();
        rr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[12];
        logic [3:0] ops[11];
        bit   got, rv, pend0, pend1;

        vt[0]  = '{0, 4'b0010, 32'd5,        32'd7,        32'd12,        0};
        vt[1]  = '{0, 4'b0110, 32'd9,        32'd9,        32'd0,         1};
        vt[2]  = '{0, 4'b0000, 32'hF0F0,     32'hFF00,     32'hF000,      0};
        vt[3]  = '{1, 4'b0001, 32'h0F00,     32'h00F0,     32'h0FF0,      0};
        vt[4]  = '{1, 4'b0011, 32'hFFFF,     32'h00FF,     32'hFF00,      0};
        vt[5]  = '{0, 4'b0101, 32'h80000000, 32'd4,        32'h08000000,  0};
        vt[6]  = '{1, 4'b0100, 32'd1,        32'd31,       32'h80000000,  0};
        vt[7]  = '{0, 4'b1001, 32'h80000000, 32'd4,        32'hF8000000,  0};
        vt[8]  = '{1, 4'b1000, 32'hFFFFFFFF, 32'd1,        32'd1,         0};
        vt[9]  = '{1, 4'b0111, 32'hFFFFFFFF, 32'd1,        32'd0,         1};
        vt[10] = '{0, 4'b1111, 32'd3,        32'd4,        32'd0,         1};
        vt[11] = '{1, 4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,         1};
        ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b0101,
                4'b0100, 4'b1001, 4'b0111, 4'b1000, 4'b1111};

        // Power-on reset and idle state.
        q.delete();
        rr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset alu_op", alu_op, 4'b0000);
        chk("reset alu_ina", alu_ina, '0);
        chk("reset alu_inb", alu_inb, '0);
        chk("reset rsp0_valid", rsp0_valid, 1'b0);
        chk("reset rsp1_valid", rsp1_valid, 1'b0);
        chk("reset rsp0_out", rsp0_out, '0);
        chk("reset rsp1_out", rsp1_out, '0);
        chk("idle req0_ready", req0_ready, 1'b0);
        chk("idle req1_ready", req1_ready, 1'b0);
        req0_valid = 1'b1;
        #1;
        chk("solo req0_ready", req0_ready, 1'b1);
        chk("solo req1_ready", req1_ready, 1'b0);
        req0_valid = 1'b0;
        #1;

        // Table of single transactions with 2-cycle latency.
        for (int i = 0; i < 12; i++) begin
            rsp0_ready = 1'b1;
            rsp1_ready = 1'b1;
            set_req(vt[i].port, vt[i].op, vt[i].a, vt[i].b);
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                step();
                got = vt[i].port ? last_acc1 : last_acc0;
            end
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            chk($sformatf("vec%0d accept", i), got, 1'b1);
            rv = vt[i].port ? rsp1_valid : rsp0_valid;
            chk($sformatf("vec%0d early valid", i), rv, 1'b0);
            step();
            rv = vt[i].port ? rsp1_valid : rsp0_valid;
            chk($sformatf("vec%0d valid", i), rv, 1'b1);
            chk($sformatf("vec%0d out", i), vt[i].port ? rsp1_out : rsp0_out, vt[i].out);
            chk($sformatf("vec%0d zero", i), vt[i].port ? rsp1_zero : rsp0_zero, vt[i].zero);
        end
        drain(3);

        // Contention from reset: grants alternate with no bubbles.
        apply_reset();
        set_req(0, 4'b0010, 32'd1, 32'd1);
        set_req(1, 4'b0011, 32'hF0, 32'h0F);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("cont grant0 k%0d", k), last_acc0, (k % 2) == 1);
            chk($sformatf("cont grant1 k%0d", k), last_acc1, (k % 2) == 0);
            if (k >= 2) begin
                chk($sformatf("cont rsp0_valid k%0d", k), rsp0_valid, (k % 2) == 0);
                chk($sformatf("cont rsp1_valid k%0d", k), rsp1_valid, (k % 2) == 1);
                chk($sformatf("cont out k%0d", k), (k % 2) == 0 ? rsp0_out : rsp1_out,
                    (k % 2) == 0 ? 32'd2 : 32'hFF);
            end
        end
        drain(3);

        // Backpressure with a port 1 response stuck in S2.
        apply_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b0;
        set_req(1, 4'b0010, 32'd3, 32'd4);
        step();
        req1_valid = 1'b0;
        set_req(0, 4'b0001, 32'd1, 32'd2);
        step();
        set_req(0, 4'b0110, 32'd10, 32'd3);
        set_req(1, 4'b0000, 32'hFF, 32'h0F);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp req0_ready", req0_ready, 1'b0);
            chk("bp req1_ready", req1_ready, 1'b0);
            chk("bp rsp1_valid", rsp1_valid, 1'b1);
            chk("bp rsp1_out", rsp1_out, 32'd7);
            chk("bp alu_op", alu_op, 4'b0001);
            chk("bp alu_ina", alu_ina, 32'd1);
        end
        rsp1_ready = 1'b1;
        step();
        if (last_acc1) req1_valid = 1'b0;
        chk("bp drain rsp0_valid", rsp0_valid, 1'b1);
        chk("bp drain rsp0_out", rsp0_out, 32'd3);
        chk("bp drain rsp1_valid", rsp1_valid, 1'b0);
        step();
        if (last_acc0) req0_valid = 1'b0;
        chk("bp next rsp1_valid", rsp1_valid, 1'b1);
        chk("bp next rsp1_out", rsp1_out, 32'h0F);
        drain(4);

        // Reset while both stages hold entries.
        rsp0_ready = 1'b0;
        set_req(0, 4'b0010, 32'd2, 32'd2);
        step();
        set_req(0, 4'b0010, 32'd3, 32'd3);
        step();
        req0_valid = 1'b0;
        chk("mid full rsp0_valid", rsp0_valid, 1'b1);
        chk("mid full rsp0_out", rsp0_out, 32'd4);
        apply_reset();
        rsp0_ready = 1'b1;
        set_req(0, 4'b0110, 32'd8, 32'd3);
        set_req(1, 4'b0010, 32'd1, 32'd1);
        #1;
        chk("post rst req0_ready", req0_ready, 1'b1);
        chk("post rst req1_ready", req1_ready, 1'b0);
        step();
        req0_valid = 1'b0;
        step();
        if (last_acc1) req1_valid = 1'b0;
        chk("post rst rsp0_valid", rsp0_valid, 1'b1);
        chk("post rst rsp0_out", rsp0_out, 32'd5);
        drain(4);

        // Randomized traffic against the model.
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!pend0 && $urandom_range(0, 2) == 0) begin
                req0_a = $urandom;
                req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
                req0_op = ops[$urandom_range(0, 10)];
                req0_valid = 1'b1;
                pend0 = 1'b1;
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                req1_a = $urandom;
                req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
                req1_op = ops[$urandom_range(0, 10)];
                req1_valid = 1'b1;
                pend1 = 1'b1;
            end
            rsp0_ready = $urandom_range(0, 3) != 0;
            rsp1_ready = $urandom_range(0, 3) != 0;
            step();
            if (last_acc0) begin pend0 = 1'b0; req0_valid = 1'b0; end
            if (last_acc1) begin pend1 = 1'b0; req1_valid = 1'b0; end
        end
        drain(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single combinational ALU instance between two requesters (port 0: integer execute path, port 1: address/branch helper) using round-robin arbitration, valid/ready handshakes on both request and response sides, and a two-stage registered pipeline (issue register, response register). The block drives the ALU's `ALUop`/`ina`/`inb` inputs from its issue register and captures `out`/`zero` into a response register tagged with the winning port.

## Interface
- `W`, default 32: operand and result width.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `req0_valid  in  1`, `req0_ready  out  1`: port 0 request handshake.
- `req0_op  in  4`, `req0_a  in  W`, `req0_b  in  W`: port 0 ALU opcode and operands.
- `rsp0_valid  out  1`, `rsp0_ready  in  1`: port 0 response handshake.
- `rsp0_out  out  W`, `rsp0_zero  out  1`: port 0 result and zero flag.
- `req1_*`, `rsp1_*`: identical set for port 1.
- `alu_op  out  4`, `alu_ina  out  W`, `alu_inb  out  W`: drive the shared ALU.
- `alu_out  in  W`, `alu_zero  in  1`: shared ALU result.

## Operation
- Opcodes are passed through unmodified. Encodings: 0010 add, 0110 sub, 0000 and, 0001 or, 0011 xor, 0101 srl, 0100 sll, 1001 sra, 0111 sltu, 1000 slt. Undefined codes are not trapped; the ALU returns 0 and zero=1.
- State:
  - S1 (issue): `s1_valid`, `s1_owner`, op, a, b.
  - S2 (response): `s2_valid`, `s2_owner`, out, zero.
  - `rr_ptr`: 1 bit, the port with priority on a tie.
- Advance rules:
  - `s2_take` = `s2_valid & rspX_ready` for X = `s2_owner`.
  - `s2_load` = `s1_valid & (~s2_valid | s2_take)`.
  - `s1_free` = `~s1_valid | s2_load`.
- Arbitration:
  - Only one request pending: that port wins.
  - Both pending: the port equal to `rr_ptr` wins.
  - `reqX_ready` = `s1_free` & (X is the winner). The loser's ready is 0.
  - `reqX_ready` may depend combinationally on `reqX_valid` and `rsp*_ready`.
- On an accepted request (valid & ready):
  - S1 loads op/a/b and owner=X, and `s1_valid` is set.
  - `rr_ptr` is set to the other port (~X), whether or not there was contention.
- On `s2_load`, S2 captures `alu_out`/`alu_zero` (computed from S1 contents) and `s1_owner`. If no new accept occurs the same cycle, `s1_valid` clears.
- On `s2_take` with no `s2_load`, `s2_valid` clears.
- Outputs:
  - `rspX_valid` = `s2_valid & (s2_owner == X)`.
  - `rspX_out`/`rspX_zero` are driven from S2 for both ports; they are meaningful only while that port's valid is high.
  - `alu_op`/`alu_ina`/`alu_inb` always reflect the S1 register contents, including stale values when S1 is empty.
- Requester contract: a requester must hold valid and its fields stable until accepted. The arbiter never drops or reorders a response. Responses return in grant order across both ports.

## Timing
- Reset (asynchronous assert, synchronous-edge release): all valids are 0, `rr_ptr`=0, S1/S2 data and owners are 0. Consequently `alu_op`=0000, `alu_ina`=`alu_inb`=0, `rsp*_valid`=0, and `rsp*_out`=0.
- Latency: a request accepted at edge N has its response valid during the cycle after edge N+1 (2 cycles), provided S2 is free.
- Throughput: one accept per cycle sustained while the response consumers hold ready=1.
- Full pipeline (S1 and S2 valid, owner not ready): both `req*_ready`=0. Contents hold unchanged, and the ALU inputs stay stable.
- Simultaneous `s2_take` and `s2_load`: S2 is replaced without a bubble. A new accept in the same cycle refills S1.
- Responses are head-of-line blocking. If port 0's response is stalled, port 1's traffic also stalls, and vice versa.
- Reset mid-operation discards in-flight S1/S2 entries with no response generated.

## Test plan
- Reset then idle: all outputs zero, `req0_ready`=1 (port 0 wins by `rr_ptr`=0 when only it is valid) → hold `req0_valid`=0 and `req1_valid`=0 and check both readies follow valid-only gating (ready is 0 for a non-valid port).
- Single request: port 0 sends op=0010, a=5, b=7 at edge N → `rsp0_valid`=1 in cycle N+2 with `rsp0_out`=12 and `rsp0_zero`=0. Then port 0 sends op=0110, a=9, b=9 → out=0, zero=1.
- Contention: both ports valid every cycle from reset, port 0 with add 1+1 and port 1 with xor 0xF0^0x0F → grants alternate 0,1,0,1. Responses alternate with out=2 and 0xFF respectively, with no bubbles.
- Backpressure: `rsp1_ready`=0 with a port 1 response in S2 and a port 0 request in S1 → both `req*_ready`=0 and all state frozen. Raising `rsp1_ready` drains port 1's response first, then port 0's on the next cycle.
- Signed vs unsigned: port 1 sends op=1000 a=0xFFFFFFFF b=1 → out=1. Then op=0111 with the same operands → out=0, zero=1.
- Reset mid-flight: assert `rst_n`=0 while S1 and S2 are both valid → `rsp*_valid` drops immediately (asynchronously). After release, the first request completes normally with `rr_ptr`=0.
